// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: byte register file behind i2c_slave; the first written byte sets the pointer, and reads and writes auto-increment it.
module i2c_slave_regfile #(
    parameter int ADDR_WIDTH = 4,
    parameter logic [8*(2**ADDR_WIDTH)-1:0] RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic                           s_last,
    output logic [7:0]                     m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           m_last,
    input  logic                           bus_addressed,
    output logic [8*(2**ADDR_WIDTH)-1:0]   regs,
    output logic                           wr_en,
    output logic [ADDR_WIDTH-1:0]          wr_addr,
    output logic [7:0]                     wr_data
);
    typedef enum logic {ST_ADDR, ST_WRITE} state_t;
    state_t                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          ptr_q, ptr_d;
    logic [8*(2**ADDR_WIDTH)-1:0]   regs_q, regs_d;
    logic [7:0]                     m_data_q, m_data_d;
    logic                           m_valid_q, m_valid_d;
    logic                           s_ready_q, s_ready_d;
    logic                           wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]          wr_addr_q, wr_addr_d;
    logic [7:0]                     wr_data_q, wr_data_d;
    logic                           bus_q, bus_d;
    logic                           s_accept, rd_hs, bus_rise;
    always_comb begin
        s_accept  = s_valid && s_ready_q;
        rd_hs     = m_valid_q && m_ready;
        bus_rise  = bus_addressed && !bus_q;
        state_d   = state_q;
        ptr_d     = ptr_q;
        regs_d    = regs_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (s_accept) begin
            if (state_q == ST_ADDR) begin
                ptr_d = s_data[ADDR_WIDTH-1:0];
            end else begin
                regs_d[{ptr_q, 3'b000} +: 8] = s_data;
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = s_data;
                ptr_d     = ptr_q + ADDR_WIDTH'(1);
            end
            state_d = s_last ? ST_ADDR : ST_WRITE;
        end else if (rd_hs) begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
        // a new addressing always restarts at the pointer byte, even mid-burst
        if (bus_rise) state_d = ST_ADDR;
        bus_d     = bus_addressed;
        s_ready_d = 1'b1;
        m_data_d  = regs_q[{ptr_q, 3'b000} +: 8];
        // m_data reloads one cycle after any pointer/register change, so hide it for that cycle
        m_valid_d = s_ready_q && !s_accept && !rd_hs;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ADDR;
            ptr_q     <= '0;
            regs_q    <= RESET_VALUE;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            bus_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            regs_q    <= regs_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            bus_q     <= bus_d;
        end
    end
    assign s_ready = s_ready_q;
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = 1'b0;
    assign regs    = regs_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Byte-wide register file that sits directly downstream of `i2c_slave` and turns its byte streams into register accesses. It consumes the slave's `data_out` stream (first byte of each write is a register pointer, further bytes are written with auto-increment) and drives the slave's `data_in` stream with register contents for reads. It also exposes the register array and a write strobe to fabric logic, giving a standard "I2C device with N registers" endpoint.

## Interface
- `ADDR_WIDTH`, default 4: pointer width; register count is `2**ADDR_WIDTH`.
- `RESET_VALUE`, default 0: flat `8*2**ADDR_WIDTH`-bit reset image; register k resets to bits `[8k+7:8k]`.

- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `s_data`  in  8  write byte from `i2c_slave.data_out`
- `s_valid`  in  1  from `data_out_valid`
- `s_ready`  out  1  to `data_out_ready`
- `s_last`  in  1  from `data_out_last`; marks the final byte before STOP or repeated START
- `m_data`  out  8  read byte to `i2c_slave.data_in`
- `m_valid`  out  1  to `data_in_valid`
- `m_ready`  in  1  from `data_in_ready`
- `m_last`  out  1  to `data_in_last`; constant 0, because the master ends reads with NAK
- `bus_addressed`  in  1  from `i2c_slave.bus_addressed`
- `regs`  out  `8*2**ADDR_WIDTH`  flat register contents; register k is at `[8k+7:8k]`
- `wr_en`  out  1  one-cycle pulse per register write
- `wr_addr`  out  `ADDR_WIDTH`  register index written
- `wr_data`  out  8  byte written

## Operation
- **State:** 2-state FSM plus pointer `ptr[ADDR_WIDTH-1:0]`.
- **`ST_ADDR`:** the next accepted `s_*` byte loads the pointer: `ptr <= s_data[ADDR_WIDTH-1:0]`. Upper bits are ignored. No register write occurs.
  - If `s_last`=0, go to `ST_WRITE`.
  - If `s_last`=1, stay in `ST_ADDR`. This is the pointer-set before a repeated-START read.
- **`ST_WRITE`:** each accepted byte does the following:
  - `reg[ptr] <= s_data`.
  - Pulse `wr_en` with `wr_addr`=`ptr` and `wr_data`=`s_data`.
  - `ptr <= ptr+1`, wrapping modulo `2**ADDR_WIDTH`.
  - If `s_last`=1, return to `ST_ADDR`.
- **Read:** each `m_valid && m_ready` handshake increments `ptr`, with wrap. The pointer persists across transactions, so consecutive reads continue sequentially.
- **Abort recovery:** a rising edge of `bus_addressed`, from a registered copy, forces `ST_ADDR`. This covers transactions that end without `s_last`. The pointer is unchanged.
- **Accept priority:** an `s_*` accept and a rising edge of `bus_addressed` in the same cycle process the byte, then land in `ST_ADDR`.
- **Simultaneous write accept and read handshake:** the write path owns `ptr`. The write increments `ptr` once. The read handshake is still honoured, but it does not add a second increment.
- **Read-data freshness:** `m_data` is registered: `m_data <= reg[ptr]` every cycle.
  - `m_valid` is forced low for the one cycle following any `ptr` change or register write. This guarantees `m_data` is never stale when `m_valid`=1.
  - Otherwise `m_valid`=1.

## Timing
- **Reset (`rst_n`=0, async):**
  - `ptr`=0 and FSM=`ST_ADDR`.
  - Registers take `RESET_VALUE`.
  - `s_ready`=0, `m_valid`=0, `m_data`=0, `m_last`=0.
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - The edge-detect register resets to 0.
- **After reset release:**
  - `s_ready` goes 1 on the first clock edge and stays 1. Every byte is accepted in one cycle, with no backpressure.
  - `m_valid` goes 1 on the second edge, once `m_data` has loaded.
- **Write latency:** for an accept at edge N, `regs`, `wr_en`, `wr_addr` and `wr_data` are valid after edge N, and `wr_en` is high for exactly one cycle. `m_data` reflects the new value after edge N+1, and `m_valid` is low during cycle N..N+1.
- **Read handshake:** for a handshake at edge N, `m_valid`=0 in the following cycle and `m_data`=`reg[ptr+1]` after edge N+1. The i2c_slave byte period is far longer than 2 cycles, so this adds no bus stretching.
- **Reset mid-transaction:** everything returns to reset values immediately. Any partially received byte from `i2c_slave` is simply never accepted.

## Test plan
- **Pointer-set then burst write:** after reset, stream 0x03, 0xAA, 0xBB (last) -> reg3=0xAA and reg4=0xBB; `wr_en` pulses twice with `wr_addr` 3 then 4; FSM returns to `ST_ADDR` and `ptr`=5.
- **Wrap-around:** write 0x0F, 0x11, 0x22 (last) with `ADDR_WIDTH`=4 -> reg15=0x11 and reg0=0x22; `ptr`=1.
- **Pointer-set plus read:** write 0x03 (last), then 3 read handshakes -> `m_data` sequence 0xAA, 0xBB, reg5 reset value; `m_valid` low for one cycle after each handshake.
- **Abort:** write 0x02, 0x55 with no `s_last`, then pulse `bus_addressed` 0->1, then write 0x07, 0x66 (last) -> reg2=0x55 and reg7=0x66; 0x07 is treated as a pointer, not data.
- **Upper pointer bits:** write 0xF4, 0x99 (last) -> reg4=0x99.
- **Reset mid-burst:** assert `rst_n`=0 after byte 0x01, 0x77 -> all registers equal `RESET_VALUE`, `ptr`=0, `s_ready`=0 and `m_valid`=0 while in reset.
